// File: rtl/smem_pkg.sv
// smem_pkg: shared types and constants for the shared-memory requester
package smem_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t RESP  = 2'd3;
    localparam int ROW_W = 8;
    localparam int DATA_W = 8;
    localparam int DEF_NUM_BANKS = 4;
endpackage

// File: rtl/smem_bank_mux.sv
// smem_bank_mux: selects one bank's read data and finish flag by index
module smem_bank_mux
    import smem_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int BANK_BITS = $clog2(NUM_BANKS)
) (
    input  logic [BANK_BITS-1:0]        sel,
    input  logic [DATA_W*NUM_BANKS-1:0] bank_rdata,
    input  logic [NUM_BANKS-1:0]        bank_finish,
    output logic [DATA_W-1:0]           rdata,
    output logic                        finish
);
    assign rdata = bank_rdata[sel*DATA_W +: DATA_W];
    assign finish = bank_finish[sel];
endmodule

// File: rtl/smem_requester.sv
// smem_requester: single-outstanding load/store initiator for the banked shared memory
module smem_requester
    import smem_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int TIMEOUT = 15,
    localparam int BANK_BITS = $clog2(NUM_BANKS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ROW_W+BANK_BITS-1:0]  req_addr,
    input  logic [DATA_W-1:0]           req_data,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        resp_err,
    output logic [NUM_BANKS-1:0]        bank_read,
    output logic [NUM_BANKS-1:0]        bank_write,
    output logic [ROW_W-1:0]            bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [DATA_W*NUM_BANKS-1:0] bank_rdata,
    input  logic [NUM_BANKS-1:0]        bank_finish,
    output logic                        busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    state_t state, state_next;
    logic [BANK_BITS-1:0] sel;
    logic write;
    logic [CNT_W-1:0] count;
    logic [DATA_W-1:0] sel_rdata;
    logic sel_finish, timed_out;
    logic [NUM_BANKS-1:0] onehot;

    smem_bank_mux #(.NUM_BANKS(NUM_BANKS)) mux (
        .sel(sel),
        .bank_rdata(bank_rdata),
        .bank_finish(bank_finish),
        .rdata(sel_rdata),
        .finish(sel_finish)
    );

    assign onehot = NUM_BANKS'(1) << req_addr[BANK_BITS-1:0];
    assign timed_out = count == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req_valid ? ISSUE : IDLE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = (sel_finish || timed_out) ? RESP : WAIT;
            default: state_next = resp_ready ? IDLE : RESP;
        endcase
    end

    always_comb begin
        req_ready = state == IDLE;
        busy = state != IDLE;
    end

    // Strobes are raised on the accept edge so they are high only during ISSUE
    always_ff @(posedge clock) begin
        if (reset) begin
            sel <= '0;
            write <= 1'b0;
            count <= '0;
            bank_read <= '0;
            bank_write <= '0;
            bank_addr <= '0;
            bank_wdata <= '0;
            resp_valid <= 1'b0;
            resp_data <= '0;
            resp_err <= 1'b0;
        end else begin
            bank_read <= '0;
            bank_write <= '0;
            case (state)
                IDLE: if (req_valid) begin
                    sel <= req_addr[BANK_BITS-1:0];
                    write <= req_write;
                    bank_addr <= req_addr[BANK_BITS +: ROW_W];
                    bank_wdata <= req_data;
                    bank_read <= req_write ? '0 : onehot;
                    bank_write <= req_write ? onehot : '0;
                end
                ISSUE: count <= '0;
                WAIT: if (sel_finish) begin
                    resp_valid <= 1'b1;
                    resp_data <= write ? '0 : sel_rdata;
                    resp_err <= 1'b0;
                end else if (timed_out) begin
                    resp_valid <= 1'b1;
                    resp_data <= '0;
                    resp_err <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
                default: if (resp_ready) resp_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_smem_requester.sv
// tb_smem_requester: scoreboard bench with a behavioural 4-bank memory model
module tb_smem_requester;
    localparam int NB = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic resp_valid, resp_ready = 1'b1, resp_err, busy;
    logic [7:0] resp_data, bank_addr, bank_wdata;
    logic [NB-1:0] bank_read, bank_write, bank_finish;
    logic [8*NB-1:0] bank_rdata;
    logic [7:0] mem [NB][256];
    logic [7:0] rd [NB];
    logic [NB-1:0] fin = '0, kill = '0, force_fin = '0;
    logic [7:0] ref_mem [1024];
    logic [8:0] sb [$];
    int n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    smem_requester #(.NUM_BANKS(NB), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .bank_read(bank_read), .bank_write(bank_write),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .bank_finish(bank_finish), .busy(busy)
    );

    // Bank model: finish one cycle after a strobe
    always @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            fin[i] <= bank_read[i] | bank_write[i];
            if (bank_write[i]) mem[i][bank_addr] <= bank_wdata;
            if (bank_read[i]) rd[i] <= mem[i][bank_addr];
        end
    end
    assign bank_rdata = {rd[3], rd[2], rd[1], rd[0]};
    assign bank_finish = (fin & ~kill) | force_fin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        logic [8:0] e;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_err", resp_err, e[8]);
            check("resp_data", resp_data, e[7:0]);
        end
    endtask

    task automatic expect_push(input logic wr, input logic [9:0] addr, input logic [7:0] data, input logic err);
        if (err) sb.push_back(9'h100);
        else if (wr) begin
            ref_mem[addr] = data;
            sb.push_back(9'h000);
        end else sb.push_back({1'b0, ref_mem[addr]});
    endtask

    task automatic drive(input logic wr, input logic [9:0] addr, input logic [7:0] data);
        check("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr = addr;
        req_data = data;
        @(negedge clock);
        req_valid = 1'b0;
        req_addr = ~addr;
        req_data = ~data;
    endtask

    task automatic xact(input logic wr, input logic [9:0] addr, input logic [7:0] data, input int exp_lat, input logic err);
        logic [NB-1:0] oh;
        int cyc, strobes;
        oh = NB'(1) << addr[1:0];
        expect_push(wr, addr, data, err);
        drive(wr, addr, data);
        check("strobe", {bank_write, bank_read}, wr ? {oh, 4'b0} : {4'b0, oh});
        check("bank_addr", bank_addr, addr[9:2]);
        if (wr) check("bank_wdata", bank_wdata, data);
        strobes = |(bank_read | bank_write) ? 1 : 0;
        cyc = 1;
        while (!resp_valid && cyc < 40) begin
            @(negedge clock);
            cyc++;
            strobes += |(bank_read | bank_write) ? 1 : 0;
        end
        check("latency", cyc, exp_lat);
        check("strobe_count", strobes, 1);
        if (resp_ready) begin
            pop_check();
            @(negedge clock);
            check("idle_after", {resp_valid, req_ready}, 2'b01);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_state", {req_ready, busy, resp_valid, resp_err}, 4'b1000);
        check("rst_strobes", {bank_read, bank_write}, 0);
        check("rst_regs", {bank_addr, bank_wdata, resp_data}, 0);
        reset = 1'b0;
        @(negedge clock);
        xact(1'b1, 10'h2A5, 8'h5C, 3, 1'b0);
        xact(1'b0, 10'h2A5, 8'h00, 3, 1'b0);
        for (int b = 0; b < NB; b++) xact(1'b1, {8'(8'h10 + b * 8'h11), 2'(b)}, 8'(8'h11 * (b + 1)), 3, 1'b0);
        for (int b = 0; b < NB; b++) xact(1'b0, {8'(8'h10 + b * 8'h11), 2'(b)}, 8'h00, 3, 1'b0);
        // Bank 3 never finishes: timeout after 15 WAIT cycles
        kill = 4'b1000;
        xact(1'b0, {8'h43, 2'd3}, 8'h00, 17, 1'b1);
        kill = '0;
        // Response backpressure with a competing request held on the lane
        resp_ready = 1'b0;
        xact(1'b0, 10'h2A5, 8'h00, 3, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 10'h3FE;
        req_data = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_valid", {resp_valid, resp_err, req_ready}, 3'b100);
            check("hold_data", resp_data, 8'h5C);
            check("hold_no_accept", bank_write, 0);
        end
        resp_ready = 1'b1;
        pop_check();
        @(negedge clock);
        check("hs_idle", req_ready, 1);
        xact(1'b1, 10'h3FE, 8'hAA, 3, 1'b0);
        // Spurious finish on bank 0 while waiting on bank 2
        kill = 4'b0100;
        expect_push(1'b0, {8'h32, 2'd2}, 8'h00, 1'b0);
        drive(1'b0, {8'h32, 2'd2}, 8'h00);
        force_fin = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("spur_ignored", resp_valid, 0);
        end
        force_fin = 4'b0100;
        @(negedge clock);
        force_fin = '0;
        check("spur_resp", resp_valid, 1);
        pop_check();
        @(negedge clock);
        kill = '0;
        // Reset during WAIT aborts with no response
        kill = 4'b0001;
        drive(1'b0, {8'h10, 2'd0}, 8'h00);
        @(negedge clock);
        check("in_wait", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_strobes", {bank_read, bank_write}, 0);
        check("abort_state", {resp_valid, busy, req_ready}, 3'b001);
        reset = 1'b0;
        kill = '0;
        @(negedge clock);
        xact(1'b0, {8'h10, 2'd0}, 8'h00, 3, 1'b0);
        check("sb_final", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/smem_requester.md
Name: smem_requester

Overview:
- Initiator side of the shared-memory bank interface: accepts one load/store request at a time from a core lane over a valid/ready handshake.
- Selects the target bank from the low address bits and drives that bank's read/write strobe for exactly one cycle.
- Waits for the bank's finish pulse, captures read data, and returns a response to the lane over a valid/ready handshake.
- Sits between the lane's load/store path and NUM_BANKS instances of the 256x8 shared-memory bank.

Parameters:
- NUM_BANKS, 4, number of banks; power of two, at least 2.
- BANK_BITS, $clog2(NUM_BANKS), bank-select width (derived; not overridable).
- TIMEOUT, 15, number of WAIT cycles without finish before an error response is returned.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  lane request valid
- req_ready  out  1  requester can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  8+BANK_BITS  [BANK_BITS-1:0] = bank, upper 8 bits = row
- req_data  in  8  store data
- resp_valid  out  1  response valid
- resp_ready  in  1  lane accepts response
- resp_data  out  8  load data (0 for stores and on error)
- resp_err  out  1  timeout occurred
- bank_read  out  NUM_BANKS  one-hot read strobe
- bank_write  out  NUM_BANKS  one-hot write strobe
- bank_addr  out  8  row address, broadcast to all banks
- bank_wdata  out  8  write data, broadcast to all banks
- bank_rdata  in  8*NUM_BANKS  bank data_out, bank i at [8i+7:8i]
- bank_finish  in  NUM_BANKS  bank finish flags
- busy  out  1  state is not IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs are registered except req_ready and busy, which are decoded from state.
- Reset: state=IDLE; bank_read=0, bank_write=0, bank_addr=0, bank_wdata=0, resp_valid=0, resp_data=0, resp_err=0, timeout counter=0. Reset in any state aborts the transaction and all strobes drop on the same edge. No response is generated.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch bank index, row, write flag and data; go to ISSUE.
- ISSUE: exactly one bit of bank_read or bank_write is high, the bit for the latched bank index. bank_addr and bank_wdata are driven. Next state is WAIT, and the strobes clear on that edge, so each strobe is a 1-cycle pulse.
- WAIT: the requester samples only bank_finish[sel]; finish from any other bank is ignored.
  - On bank_finish[sel]=1: resp_data = bank_rdata[sel] for loads, 0 for stores; resp_err=0; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: resp_err=1, resp_data=0, go to RESP.
  - The counter clears on entry to WAIT.
- Latency: bank finish arrives in the first WAIT cycle, so request accept to resp_valid is 3 cycles.
- RESP: resp_valid=1; resp_data and resp_err are held stable until resp_ready. On resp_ready: resp_valid=0, go to IDLE. No new request is accepted in the same cycle (req_ready=0 in RESP).
- Handshakes: only one transaction is outstanding at a time. Changes to the req_* inputs while not in IDLE are ignored. Backpressure on resp_ready can stall the FSM indefinitely.
- A bank index is always in range because NUM_BANKS is a power of two.

Decomposition:
- Shared package smem_pkg:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - ROW_W=8 and DATA_W=8
  - default NUM_BANKS
- Sub-module smem_bank_mux: combinational NUM_BANKS:1 select of bank_rdata and bank_finish by index.
- The FSM and one-hot strobe generation stay in smem_requester.

Test Plan:
- Reset, then a store of addr 10'h2A5 (bank 1, row 0xA9) with data 0x5C: bank_write=4'b0010 for one cycle; resp_valid 3 cycles after accept; resp_err=0; resp_data=0.
- Load of the same address after that store: bank_read=4'b0010 pulse; resp_data=0x5C. Four back-to-back stores/loads, one per bank, each return the correct data.
- Load to bank 3 with bank_finish tied low: resp_err=1 and resp_data=0 after 15 WAIT cycles; no strobe re-issue.
- Hold resp_ready=0 for 10 cycles: resp_valid stays 1 with data stable; req_ready=0; a new req_valid is not accepted until after the handshake.
- Spurious bank_finish[0]=1 while waiting on bank 2: ignored; the response arrives on bank_finish[2].
- Assert reset during WAIT: on the next cycle all strobes=0, resp_valid=0, state=IDLE, req_ready=1.
